serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 106 ++++++++++
 tb/tb_serial_adder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell and a registered carry, LSB first, valid/ready handshakes.
// Define SERIAL_ADDER_SUB_EN to add a 'sub' input that selects a - b instead of a + b + cin.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg;
  logic             carry;
  logic [WIDTH-1:0] b_in;
  logic             c_in;
  logic             accept, last;
  logic             bit_a, bit_b, bit_s, bit_c;

  // Subtraction is folded into the operand latch: invert b and force the carry-in.
`ifdef SERIAL_ADDER_SUB_EN
  assign b_in = sub ? ~b : b;
  assign c_in = sub ? 1'b1 : cin;
`else
  assign b_in = b;
  assign c_in = cin;
`endif

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CW'(WIDTH - 1));

  // The single full-adder cell.
  assign bit_a = a_reg[cnt];
  assign bit_b = b_reg[cnt];
  assign bit_s = bit_a ^ bit_b ^ carry;
  assign bit_c = (bit_a & bit_b) | (carry & (bit_a ^ bit_b));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first, so no path through the case leaves state_next unassigned (no latch).
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == DONE);
  end

  // NOTE: operand registers are only read in RUN after a load, so they carry no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_reg <= a;
      b_reg <= b_in;
    end
  end

  // Result bits only move during RUN; cout and ovf are committed on the MSB edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else if (accept) begin
      cnt   <= '0;
      carry <= c_in;
    end else if (state == RUN) begin
      sum[cnt] <= bit_s;
      carry    <= bit_c;
      cnt      <= cnt + 1'b1;
      if (last) begin
        cout <= bit_c;
        ovf  <= carry ^ bit_c;
      end
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: vector table at WIDTH=8, hand sequences for
// backpressure and mid-operation reset, and the full-adder truth table at WIDTH=1.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic         in_ready, out_valid, cout, ovf;
  logic [W-1:0] sum;
  logic         sub = 1'b0;

  logic         in_valid1 = 1'b0, out_ready1 = 1'b1, cin1 = 1'b0;
  logic [0:0]   a1 = '0, b1 = '0;
  logic         in_ready1, out_valid1, cout1, ovf1;
  logic [0:0]   sum1;
  logic         sub1 = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub(sub1),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1),
    .sum(sum1), .cout(cout1), .ovf(ovf1)
  );

  typedef struct {
    logic [W-1:0] a, b;
    logic         cin, sub;
    logic [W-1:0] sum;
    logic         cout, ovf;
  } vec_t;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // One full transaction on the WIDTH=8 instance; out_ready is held high during RUN to show it is ignored.
  task automatic do_op(input string name, input vec_t v);
    int  n;
    int  lat;
    bit  busy_ok;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    check({name, " ready"}, in_ready, 1);
    a = v.a; b = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = ~v.a; b = W'($urandom); cin = ~v.cin; sub = ~v.sub;
    lat = 0; busy_ok = 1'b1;
    while (!out_valid && lat < 3 * W) begin
      if (in_ready) busy_ok = 1'b0;
      @(posedge clk); #1; lat++;
    end
    if (in_ready) busy_ok = 1'b0;
    check({name, " latency"}, lat, W);
    check({name, " in_ready low while busy"}, busy_ok, 1);
    check({name, " sum"}, sum, v.sum);
    check({name, " cout"}, cout, v.cout);
    check({name, " ovf"}, ovf, v.ovf);
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({name, " out_valid after transfer"}, out_valid, 0);
    check({name, " in_ready after transfer"}, in_ready, 1);
  endtask

  task automatic do_op1(input logic va, input logic vb, input logic vc);
    int         lat;
    logic [1:0] exp;
    string      name;
    name = $sformatf("w1 a=%0d b=%0d c=%0d", va, vb, vc);
    exp = 2'(va) + 2'(vb) + 2'(vc);
    a1 = va; b1 = vb; cin1 = vc; in_valid1 = 1'b1;
    @(posedge clk); #1;
    in_valid1 = 1'b0; a1 = ~va; b1 = ~vb; cin1 = ~vc;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      @(posedge clk); #1; lat++;
    end
    check({name, " latency"}, lat, 1);
    check({name, " sum"}, sum1, exp[0]);
    check({name, " cout"}, cout1, exp[1]);
    check({name, " ovf"}, ovf1, vc ^ exp[1]);
    @(posedge clk); #1;
    check({name, " back to idle"}, in_ready1, 1);
  endtask

  vec_t vecs[9];
  vec_t subv[3];

  initial begin
    int   lat;
    bit   held_ok;
    vec_t v;

    vecs[0] = '{a:8'h7F, b:8'h01, cin:0, sub:0, sum:8'h80, cout:0, ovf:1};
    vecs[1] = '{a:8'hFF, b:8'h01, cin:1, sub:0, sum:8'h01, cout:1, ovf:0};
    vecs[2] = '{a:8'h12, b:8'h34, cin:0, sub:0, sum:8'h46, cout:0, ovf:0};
    vecs[3] = '{a:8'h00, b:8'h00, cin:0, sub:0, sum:8'h00, cout:0, ovf:0};
    vecs[4] = '{a:8'h00, b:8'h00, cin:1, sub:0, sum:8'h01, cout:0, ovf:0};
    vecs[5] = '{a:8'hFF, b:8'hFF, cin:1, sub:0, sum:8'hFF, cout:1, ovf:0};
    vecs[6] = '{a:8'h80, b:8'h80, cin:0, sub:0, sum:8'h00, cout:1, ovf:1};
    vecs[7] = '{a:8'h55, b:8'hAA, cin:0, sub:0, sum:8'hFF, cout:0, ovf:0};
    vecs[8] = '{a:8'h64, b:8'h64, cin:0, sub:0, sum:8'hC8, cout:0, ovf:1};
    subv[0] = '{a:8'h05, b:8'h07, cin:0, sub:1, sum:8'hFE, cout:0, ovf:0};
    subv[1] = '{a:8'h80, b:8'h01, cin:1, sub:1, sum:8'h7F, cout:1, ovf:1};
    subv[2] = '{a:8'h10, b:8'h01, cin:1, sub:0, sum:8'h12, cout:0, ovf:0};

    // Reset state.
    #12;
    check("reset in_ready", in_ready, 0);
    check("reset out_valid", out_valid, 0);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("in_ready after reset", in_ready, 1);

    for (int i = 0; i < 9; i++) do_op($sformatf("vec%0d", i), vecs[i]);
`ifdef SERIAL_ADDER_SUB_EN
    for (int i = 0; i < 3; i++) do_op($sformatf("subvec%0d", i), subv[i]);
`endif

    // Backpressure: result held while out_ready is low, new offers ignored.
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 3 * W) begin
      @(posedge clk); #1; lat++;
    end
    check("bp latency", lat, W);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
      @(posedge clk); #1;
      check($sformatf("bp out_valid held %0d", i), out_valid, 1);
      check($sformatf("bp sum held %0d", i), sum, 8'h46);
      check($sformatf("bp in_ready low %0d", i), in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp out_valid dropped", out_valid, 0);
    check("bp idle", in_ready, 1);
    check("bp sum kept after transfer", sum, 8'h46);
    held_ok = 1'b1;
    repeat (W + 2) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) held_ok = 1'b0;
    end
    check("bp no stray operation", held_ok, 1);

    // Reset mid-RUN at bit 3.
    a = 8'hAA; b = 8'h55; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrun rst out_valid", out_valid, 0);
    check("midrun rst in_ready", in_ready, 0);
    check("midrun rst sum", sum, 0);
    check("midrun rst cout", cout, 0);
    check("midrun rst ovf", ovf, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    held_ok = 1'b1;
    repeat (W + 4) begin
      @(posedge clk); #1;
      if (out_valid) held_ok = 1'b0;
    end
    check("midrun no result emitted", held_ok, 1);
    v = '{a:8'h01, b:8'h01, cin:0, sub:0, sum:8'h02, cout:0, ovf:0};
    do_op("after midrun reset", v);

    // Reset while DONE waits for out_ready.
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (W) @(posedge clk);
    #1;
    check("middone out_valid before rst", out_valid, 1);
    rst = 1'b1;
    #1;
    check("middone rst out_valid", out_valid, 0);
    check("middone rst sum", sum, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("middone idle after rst", in_ready, 1);

    // WIDTH=1 full-adder truth table.
    for (int i = 0; i < 8; i++) do_op1(i[2], i[1], i[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
